lift_row_split: RTL and testbench

- Upstream feeder for the mult_mul_add predict stage in the JPEG-2000 5/3 lifting path.
- Accepts one row of fixed-point samples over a valid/ready stream and de-interleaves it into the even, odd, left and right pixel RAMs.
- Applies right-edge symmetric extension to the right RAM.
- Pulses done when the row is fully written, so the predict stage can start.

---
 rtl/lift_pkg.sv | 21 ++
 rtl/lift_row_split_if.sv | 12 +
 rtl/lift_row_split.sv | 162 ++++++++++++++++
 tb/tb_lift_row_split.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared definitions for the 5/3 lifting path (row splitter and predict stage).
package lift_pkg;

    localparam int DATA_W  = 26;
    localparam int ADDR_W  = 7;
    localparam int MAX_ROW = 2 * (2 ** ADDR_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        EXTEND = 2'd2,
        DONE   = 2'd3
    } lift_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } wr_port_t;

endpackage

// File: rtl/lift_row_split_if.sv
// Valid/ready sample stream feeding the row splitter.
interface lift_row_split_if;
    import lift_pkg::*;

    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/lift_row_split.sv
// De-interleaves one sample row into even/odd/left/right pixel RAMs and
// writes the right-edge symmetric extension before signalling done.
//
// state  | meaning
// IDLE   | waiting for start; rejects odd row lengths with err
// FILL   | accepting samples, one RAM write set per beat
// EXTEND | writes r[K-1] = last even sample
// DONE   | raises done next cycle, returns to IDLE
module lift_row_split
    import lift_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [ADDR_W:0]     row_len_i,
    lift_row_split_if.slave     in_if,
    output logic [ADDR_W-1:0]   pix_addr_even_o,
    output logic [DATA_W-1:0]   pix_din_even_o,
    output logic                pix_we_even_o,
    output logic [ADDR_W-1:0]   pix_addr_odd_o,
    output logic [DATA_W-1:0]   pix_din_odd_o,
    output logic                pix_we_odd_o,
    output logic [ADDR_W-1:0]   pix_addr_l_o,
    output logic [DATA_W-1:0]   pix_din_l_o,
    output logic                pix_we_l_o,
    output logic [ADDR_W-1:0]   pix_addr_r_o,
    output logic [DATA_W-1:0]   pix_din_r_o,
    output logic                pix_we_r_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    lift_state_e       state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    // K is held modulo 2^ADDR_W: a full 256-sample row stores K=0, which still
    // yields the right last index (2K-1 wraps to 255) and last address (K-1 = 127).
    logic [ADDR_W-1:0] k_q, k_d;
    logic [DATA_W-1:0] last_even_q, last_even_d;
    wr_port_t          wr_even_q, wr_even_d;
    wr_port_t          wr_odd_q, wr_odd_d;
    wr_port_t          wr_l_q, wr_l_d;
    wr_port_t          wr_r_q, wr_r_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              beat;
    logic [ADDR_W-1:0] half;
    logic [ADDR_W:0]   last_idx;

    assign in_if.ready = (state_q == FILL);
    assign beat        = in_if.valid && (state_q == FILL);
    assign half        = idx_q[ADDR_W:1];
    assign last_idx    = {k_q, 1'b0} - {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        k_d         = k_q;
        last_even_d = last_even_q;
        wr_even_d   = wr_even_q;
        wr_even_d.we = 1'b0;
        wr_odd_d    = wr_odd_q;
        wr_odd_d.we = 1'b0;
        wr_l_d      = wr_l_q;
        wr_l_d.we   = 1'b0;
        wr_r_d      = wr_r_q;
        wr_r_d.we   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start_i) begin
                    if (row_len_i[0]) begin
                        err_d = 1'b1;
                    end else begin
                        k_d     = row_len_i[ADDR_W:1];
                        idx_d   = '0;
                        busy_d  = 1'b1;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (beat) begin
                    idx_d = idx_q + 1'b1;
                    if (!idx_q[0]) begin
                        wr_even_d   = '{we: 1'b1, addr: half, din: in_if.data};
                        wr_l_d      = '{we: 1'b1, addr: half, din: in_if.data};
                        last_even_d = in_if.data;
                        if (half != '0) begin
                            wr_r_d = '{we: 1'b1, addr: half - 1'b1, din: in_if.data};
                        end
                    end else begin
                        wr_odd_d = '{we: 1'b1, addr: half, din: in_if.data};
                    end
                    if (idx_q == last_idx) begin
                        state_d = EXTEND;
                    end
                end
            end
            EXTEND: begin
                wr_r_d  = '{we: 1'b1, addr: k_q - 1'b1, din: last_even_q};
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            k_q         <= '0;
            last_even_q <= '0;
            wr_even_q   <= '0;
            wr_odd_q    <= '0;
            wr_l_q      <= '0;
            wr_r_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            k_q         <= k_d;
            last_even_q <= last_even_d;
            wr_even_q   <= wr_even_d;
            wr_odd_q    <= wr_odd_d;
            wr_l_q      <= wr_l_d;
            wr_r_q      <= wr_r_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign pix_addr_even_o = wr_even_q.addr;
    assign pix_din_even_o  = wr_even_q.din;
    assign pix_we_even_o   = wr_even_q.we;
    assign pix_addr_odd_o  = wr_odd_q.addr;
    assign pix_din_odd_o   = wr_odd_q.din;
    assign pix_we_odd_o    = wr_odd_q.we;
    assign pix_addr_l_o    = wr_l_q.addr;
    assign pix_din_l_o     = wr_l_q.din;
    assign pix_we_l_o      = wr_l_q.we;
    assign pix_addr_r_o    = wr_r_q.addr;
    assign pix_din_r_o     = wr_r_q.din;
    assign pix_we_r_o      = wr_r_q.we;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_lift_row_split.sv
// Scoreboard bench for lift_row_split: the driver queues expected RAM writes,
// done and err pulses with their cycle; a negedge monitor pops and compares.
module tb_lift_row_split;
    import lift_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   row_len;
    logic [ADDR_W-1:0] a_even, a_odd, a_l, a_r;
    logic [DATA_W-1:0] d_even, d_odd, d_l, d_r;
    logic              we_even, we_odd, we_l, we_r;
    logic              busy, done, err;

    lift_row_split_if sif ();

    lift_row_split dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start),
        .row_len_i       (row_len),
        .in_if           (sif.slave),
        .pix_addr_even_o (a_even),
        .pix_din_even_o  (d_even),
        .pix_we_even_o   (we_even),
        .pix_addr_odd_o  (a_odd),
        .pix_din_odd_o   (d_odd),
        .pix_we_odd_o    (we_odd),
        .pix_addr_l_o    (a_l),
        .pix_din_l_o     (d_l),
        .pix_we_l_o      (we_l),
        .pix_addr_r_o    (a_r),
        .pix_din_r_o     (d_r),
        .pix_we_r_o      (we_r),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  n_chk  = 0;
    int  n_fail = 0;
    wr_t q_even[$], q_odd[$], q_l[$], q_r[$];
    int  q_done[$], q_err[$];
    logic [DATA_W-1:0] sh_even[128], sh_odd[128], sh_l[128], sh_r[128];
    logic [DATA_W-1:0] last_even;
    int  samp[256];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint w26(input int v);
        logic [DATA_W-1:0] t;
        t = DATA_W'(v);
        return longint'(t);
    endfunction

    task automatic mon_wr(input int id, input string nm, input logic we,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        bit  have;
        if (we !== 1'b1) return;
        have = 1'b0;
        case (id)
            0: begin sh_even[a] = d; if (q_even.size() > 0) begin e = q_even.pop_front(); have = 1'b1; end end
            1: begin sh_odd[a]  = d; if (q_odd.size()  > 0) begin e = q_odd.pop_front();  have = 1'b1; end end
            2: begin sh_l[a]    = d; if (q_l.size()    > 0) begin e = q_l.pop_front();    have = 1'b1; end end
            default: begin sh_r[a] = d; if (q_r.size() > 0) begin e = q_r.pop_front(); have = 1'b1; end end
        endcase
        chk({"we_expected_", nm}, longint'(have), 1);
        if (have) begin
            chk({"addr_", nm}, longint'(a), longint'(e.addr));
            chk({"din_", nm}, longint'(d), longint'(e.data));
            chk({"we_cycle_", nm}, longint'(cyc), longint'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        bit have;
        mon_wr(0, "even", we_even, a_even, d_even);
        mon_wr(1, "odd", we_odd, a_odd, d_odd);
        mon_wr(2, "l", we_l, a_l, d_l);
        mon_wr(3, "r", we_r, a_r, d_r);
        if (done === 1'b1) begin
            have = q_done.size() > 0;
            chk("done_expected", longint'(have), 1);
            if (have) chk("done_cycle", longint'(cyc), longint'(q_done.pop_front()));
        end
        if (err === 1'b1) begin
            have = q_err.size() > 0;
            chk("err_expected", longint'(have), 1);
            if (have) chk("err_cycle", longint'(cyc), longint'(q_err.pop_front()));
        end
    end

    function automatic int pending();
        return q_even.size() + q_odd.size() + q_l.size() + q_r.size()
             + q_done.size() + q_err.size();
    endfunction

    task automatic clear_shadow();
        for (int i = 0; i < 128; i++) begin
            sh_even[i] = '1; sh_odd[i] = '1; sh_l[i] = '1; sh_r[i] = '1;
        end
    endtask

    task automatic pulse_start(input int len);
        start   = 1'b1;
        row_len = (ADDR_W+1)'(len);
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send(input int i, input int K, input int gap);
        int  n;
        wr_t w;
        int  e;
        repeat (gap) begin sif.valid = 1'b0; @(negedge clk); end
        sif.valid = 1'b1;
        sif.data  = DATA_W'(samp[i]);
        n = 0;
        while (sif.ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) begin
            chk("ready_timeout", longint'(n), 0);
            sif.valid = 1'b0;
            return;
        end
        e      = cyc + 1;
        w.addr = ADDR_W'(i / 2);
        w.data = DATA_W'(samp[i]);
        w.cyc  = e;
        if (i % 2 == 0) begin
            q_even.push_back(w);
            q_l.push_back(w);
            if (i > 0) begin w.addr = ADDR_W'(i / 2 - 1); q_r.push_back(w); end
            last_even = DATA_W'(samp[i]);
        end else begin
            q_odd.push_back(w);
            if (i == 2 * K - 1) begin
                w.addr = ADDR_W'(K - 1);
                w.data = last_even;
                w.cyc  = e + 1;
                q_r.push_back(w);
                q_done.push_back(e + 2);
            end
        end
        @(negedge clk);
        sif.valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (pending() != 0 && n < 50) begin @(negedge clk); n++; end
        chk({"drained_", nm}, longint'(pending()), 0);
        repeat (2) @(negedge clk);
        chk({"idle_busy_", nm}, longint'(busy), 0);
    endtask

    task automatic run_row(input int len, input bit toggle, input bit mid_start);
        int K = len / 2;
        clear_shadow();
        pulse_start(len);
        chk("busy_after_start", longint'(busy), 1);
        for (int i = 0; i < len; i++) begin
            if (mid_start && i == 2) begin start = 1'b1; row_len = 8'd4; end
            if (mid_start && i == 5) begin start = 1'b0; row_len = 8'd0; end
            send(i, K, (toggle && i > 0) ? 1 : 0);
        end
        drain($sformatf("row%0d", len));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        row_len   = '0;
        sif.valid = 1'b0;
        sif.data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_err", longint'(err), 0);
        chk("rst_ready", longint'(sif.ready), 0);
        chk("rst_we_any", longint'({we_even, we_odd, we_l, we_r}), 0);
        chk("rst_addr_even", longint'(a_even), 0);
        chk("rst_din_r", longint'(d_r), 0);
        rst = 1'b0;
        @(negedge clk);

        // 8 samples 10..17, continuous valid
        for (int i = 0; i < 8; i++) samp[i] = 10 + i;
        run_row(8, 1'b0, 1'b0);
        chk("r8_even0", longint'(sh_even[0]), 10);
        chk("r8_even3", longint'(sh_even[3]), 16);
        chk("r8_odd0", longint'(sh_odd[0]), 11);
        chk("r8_odd3", longint'(sh_odd[3]), 17);
        chk("r8_l2", longint'(sh_l[2]), 14);
        chk("r8_r0", longint'(sh_r[0]), 12);
        chk("r8_r1", longint'(sh_r[1]), 14);
        chk("r8_r2", longint'(sh_r[2]), 16);
        chk("r8_r3", longint'(sh_r[3]), 16);

        // same row, valid toggling, with an ignored start mid-FILL
        run_row(8, 1'b1, 1'b1);
        chk("r8t_even1", longint'(sh_even[1]), 12);
        chk("r8t_odd2", longint'(sh_odd[2]), 15);
        chk("r8t_r3", longint'(sh_r[3]), 16);
        chk("r8t_r0", longint'(sh_r[0]), 12);

        // shortest row, signed data
        samp[0] = -5;
        samp[1] = 7;
        run_row(2, 1'b0, 1'b0);
        chk("r2_even0", longint'(sh_even[0]), w26(-5));
        chk("r2_odd0", longint'(sh_odd[0]), w26(7));
        chk("r2_l0", longint'(sh_l[0]), w26(-5));
        chk("r2_r0", longint'(sh_r[0]), w26(-5));

        // full 256-sample row encoded as row_len = 0
        for (int i = 0; i < 256; i++) samp[i] = i;
        run_row(256, 1'b0, 1'b0);
        chk("r256_even127", longint'(sh_even[127]), 254);
        chk("r256_odd127", longint'(sh_odd[127]), 255);
        chk("r256_r126", longint'(sh_r[126]), 254);
        chk("r256_r127", longint'(sh_r[127]), 254);
        chk("r256_l64", longint'(sh_l[64]), 128);

        // illegal odd length
        q_err.push_back(cyc + 1);
        pulse_start(7);
        for (int i = 0; i < 4; i++) begin
            chk("err_busy_low", longint'(busy), 0);
            chk("err_ready_low", longint'(sif.ready), 0);
            @(negedge clk);
        end
        chk("err_drained", longint'(pending()), 0);

        // reset after 5 beats of an 8-sample row
        for (int i = 0; i < 8; i++) samp[i] = 100 + i;
        pulse_start(8);
        for (int i = 0; i < 5; i++) send(i, 4, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_we_any", longint'({we_even, we_odd, we_l, we_r}), 0);
        chk("abort_ready", longint'(sif.ready), 0);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_pending", longint'(pending()), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) samp[i] = 40 - 3 * i;
        run_row(4, 1'b0, 1'b0);
        chk("r4_even1", longint'(sh_even[1]), 34);
        chk("r4_odd1", longint'(sh_odd[1]), 31);
        chk("r4_r0", longint'(sh_r[0]), 34);
        chk("r4_r1", longint'(sh_r[1]), 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
